noc_address_demap_ctrl: RTL

// - Inverse of the global address map: splits a CPU global address into {node, offset}, global = node*1024 + offset.
// - Local hits go to this node's data memory; remote hits become NoC request packets, and the block waits for the reply.
// - Sits between the CPU data port and the local memory / NoC router interface.
// - Stalls the CPU via busywait.

---
 rtl/noc_address_demap_ctrl_pkg.sv | 23 ++
 rtl/noc_address_demap_ctrl_address_demap.sv | 24 ++
 rtl/noc_address_demap_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/noc_address_demap_ctrl_pkg.sv
// Shared types for the NoC address demapper: controller state codes, request
// packet type codes and the value returned when a remote request times out.
// Packet layout (default widths, LSB first): data[31:0], offset[41:32],
// dst[45:42], src[49:46], type[50]. Reply layout: data[31:0], src[35:32].
package noc_address_demap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOCAL    = 3'd1,
        ST_NOC_SEND = 3'd2,
        ST_NOC_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic {
        PKT_READ  = 1'b0,
        PKT_WRITE = 1'b1
    } pkt_type_e;

    localparam int          TIMEOUT_CNT_W    = 16;
    localparam logic [31:0] TIMEOUT_READDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/noc_address_demap_ctrl_address_demap.sv
// Combinational split of a global CPU address into {destination node, local
// offset}, plus a bad-request flag for out-of-map addresses or a request that
// asserts read and write together.
module noc_address_demap_ctrl_address_demap #(
    parameter int NODE_BITS   = 4,
    parameter int OFFSET_BITS = 10,
    parameter int ADDR_W      = 32
) (
    input  logic [ADDR_W-1:0]      address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic [NODE_BITS-1:0]   dst_o,
    output logic [OFFSET_BITS-1:0] off_o,
    output logic                   bad_o
);

    // Field extraction and bad-request detection.
    always_comb begin
        dst_o = address_i[OFFSET_BITS +: NODE_BITS];
        off_o = address_i[OFFSET_BITS-1:0];
        bad_o = (|address_i[ADDR_W-1:OFFSET_BITS+NODE_BITS]) | (read_i & write_i);
    end

endmodule

// File: rtl/noc_address_demap_ctrl.sv
// CPU-side address demapper: local accesses go to this node's data memory,
// remote accesses become NoC request packets and wait for a matching reply.
// Optional feature macro: REMOTE_TIMEOUT_EN (bounds the wait for a reply).
module noc_address_demap_ctrl
    import noc_address_demap_ctrl_pkg::*;
#(
    parameter int NODE_BITS      = 4,
    parameter int OFFSET_BITS    = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                       CLK,
    input  logic                                       RESETN,
    input  logic [NODE_BITS-1:0]                       NODEADDRESS,
    input  logic                                       CPU_READ,
    input  logic                                       CPU_WRITE,
    input  logic [31:0]                                CPU_ADDRESS,
    input  logic [DATA_W-1:0]                          CPU_WRITEDATA,
    output logic [DATA_W-1:0]                          CPU_READDATA,
    output logic                                       CPU_BUSYWAIT,
    output logic                                       CPU_ERROR,
    output logic                                       LMEM_READ,
    output logic                                       LMEM_WRITE,
    output logic [OFFSET_BITS-1:0]                     LMEM_ADDRESS,
    output logic [DATA_W-1:0]                          LMEM_WRITEDATA,
    input  logic [DATA_W-1:0]                          LMEM_READDATA,
    input  logic                                       LMEM_BUSYWAIT,
    output logic                                       TX_VALID,
    input  logic                                       TX_READY,
    output logic [2*NODE_BITS+OFFSET_BITS+DATA_W:0]    TX_PACKET,
    input  logic                                       RX_VALID,
    output logic                                       RX_READY,
    input  logic [NODE_BITS+DATA_W-1:0]                RX_PACKET
);

    logic [NODE_BITS-1:0]   dec_dst_s;
    logic [OFFSET_BITS-1:0] dec_off_s;
    logic                   dec_bad_s;
    logic                   req_s;
    logic                   rx_match_s;

    state_e                 state_q,  state_d;
    pkt_type_e              op_q,     op_d;
    logic [NODE_BITS-1:0]   dst_q,    dst_d;
    logic [NODE_BITS-1:0]   src_q,    src_d;
    logic [OFFSET_BITS-1:0] off_q,    off_d;
    logic [DATA_W-1:0]      wdata_q,  wdata_d;
    logic [DATA_W-1:0]      rdata_q,  rdata_d;
    logic                   err_q,    err_d;
`ifdef REMOTE_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] cnt_q,  cnt_d;
`endif

    noc_address_demap_ctrl_address_demap #(
        .NODE_BITS   (NODE_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .ADDR_W      (32)
    ) u_address_demap (
        .address_i (CPU_ADDRESS),
        .read_i    (CPU_READ),
        .write_i   (CPU_WRITE),
        .dst_o     (dec_dst_s),
        .off_o     (dec_off_s),
        .bad_o     (dec_bad_s)
    );

    // Request present and reply-source qualification.
    always_comb begin
        req_s      = CPU_READ | CPU_WRITE;
        rx_match_s = RX_VALID & (RX_PACKET[DATA_W +: NODE_BITS] == dst_q);
    end

    // Next-state and capture-register logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef REMOTE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    op_d    = CPU_WRITE ? PKT_WRITE : PKT_READ;
                    dst_d   = dec_dst_s;
                    src_d   = NODEADDRESS;
                    off_d   = dec_off_s;
                    wdata_d = CPU_WRITEDATA;
                    rdata_d = {DATA_W{1'b0}};
                    if (dec_bad_s) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (dec_dst_s == NODEADDRESS) begin
                        err_d   = 1'b0;
                        state_d = ST_LOCAL;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_NOC_SEND;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCAL: begin
                if (!LMEM_BUSYWAIT) begin
                    rdata_d = (op_q == PKT_READ) ? LMEM_READDATA : {DATA_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOCAL;
                end
            end
            ST_NOC_SEND: begin
                if (TX_READY) begin
                    state_d = ST_NOC_WAIT;
`ifdef REMOTE_TIMEOUT_EN
                    cnt_d   = {TIMEOUT_CNT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_NOC_SEND;
                end
            end
            ST_NOC_WAIT: begin
                // Replies from other nodes are consumed (RX_READY=1) and dropped.
                if (rx_match_s) begin
                    rdata_d = (op_q == PKT_READ) ? RX_PACKET[DATA_W-1:0] : {DATA_W{1'b0}};
                    state_d = ST_DONE;
`ifdef REMOTE_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = DATA_W'(TIMEOUT_READDATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_NOC_WAIT;
`else
                end else begin
                    state_d = ST_NOC_WAIT;
`endif
                end
            end
            ST_DONE: begin
                rdata_d = {DATA_W{1'b0}};
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any in-flight transaction.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            op_q    <= PKT_READ;
            dst_q   <= {NODE_BITS{1'b0}};
            src_q   <= {NODE_BITS{1'b0}};
            off_q   <= {OFFSET_BITS{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            err_q   <= 1'b0;
`ifdef REMOTE_TIMEOUT_EN
            cnt_q   <= {TIMEOUT_CNT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef REMOTE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Output decode from state and captured request; BUSYWAIT in IDLE is
    // combinational so the CPU stalls in the same cycle it issues a request.
    always_comb begin
        CPU_READDATA   = {DATA_W{1'b0}};
        CPU_BUSYWAIT   = 1'b0;
        CPU_ERROR      = 1'b0;
        LMEM_READ      = 1'b0;
        LMEM_WRITE     = 1'b0;
        LMEM_ADDRESS   = {OFFSET_BITS{1'b0}};
        LMEM_WRITEDATA = {DATA_W{1'b0}};
        TX_VALID       = 1'b0;
        TX_PACKET      = {(2*NODE_BITS+OFFSET_BITS+DATA_W+1){1'b0}};
        RX_READY       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CPU_BUSYWAIT = RESETN & req_s;
            end
            ST_LOCAL: begin
                CPU_BUSYWAIT   = 1'b1;
                LMEM_READ      = (op_q == PKT_READ);
                LMEM_WRITE     = (op_q == PKT_WRITE);
                LMEM_ADDRESS   = off_q;
                LMEM_WRITEDATA = wdata_q;
            end
            ST_NOC_SEND: begin
                CPU_BUSYWAIT = 1'b1;
                TX_VALID     = 1'b1;
                TX_PACKET    = {op_q, src_q, dst_q, off_q, wdata_q};
            end
            ST_NOC_WAIT: begin
                CPU_BUSYWAIT = 1'b1;
                RX_READY     = 1'b1;
            end
            ST_DONE: begin
                CPU_READDATA = rdata_q;
                CPU_ERROR    = err_q;
            end
            default: begin
                CPU_BUSYWAIT = 1'b0;
            end
        endcase
    end

endmodule
